// File: rtl/rx_phase_sync.sv
// Symbol timing recovery: accumulates |sample| per oversampling phase over a
// window of 2^NB_WIN symbols, picks the strongest phase and slices BPSK there.

module rx_phase_acc #(
    parameter int NB     = 8,
    parameter int NB_ACC = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              add,
    input  logic [NB-1:0]     load_val,
    input  logic [NB-1:0]     mag,
    output logic [NB_ACC-1:0] acc
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      acc <= '0;
        else if (clear) acc <= '0;
        else if (load)  acc <= NB_ACC'(load_val);
        else if (add)   acc <= acc + NB_ACC'(mag);
    end
endmodule

module rx_phase_sync #(
    parameter int NB     = 8,
    parameter int OS     = 4,
    parameter int NB_OS  = 2,
    parameter int NB_WIN = 10,
    parameter int NB_ACC = NB + NB_WIN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic [NB-1:0]    i_sample,
    output logic             o_bit,
    output logic             o_valid,
    output logic [NB_OS-1:0] o_phase,
    output logic             o_locked
);
    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    state_t                       state_q, state_d;
    logic   [NB_OS-1:0]           ph_q, cur_ph, sel, eff_ph;
    logic   [NB_WIN-1:0]          sym_q;
    logic   [OS-1:0][NB_ACC-1:0]  acc;
    logic   [NB_ACC-1:0]          best;
    logic   [NB-1:0]              mag;
    logic                         active, start, close, dec;

    always_comb begin
        mag    = i_sample[NB-1] ? (~i_sample + NB'(1)) : i_sample;
        cur_ph = i_valid ? '0 : ph_q + NB_OS'(1);
        active = i_enable && (state_q != IDLE);
        start  = i_enable && (state_q == IDLE) && i_valid;
        close  = active && i_valid && (sym_q == '1);
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        best = acc[0];
        sel  = '0;
        for (int i = 1; i < OS; i++) begin
            if (acc[i] > best) begin
                best = acc[i];
                sel  = NB_OS'(i);
            end
        end
    end

    // Using sel on the close cycle lets phase 0 of the new symbol decide at once.
    always_comb begin
        eff_ph = close ? sel : o_phase;
        dec    = i_enable && (state_q == TRACK) && (cur_ph == eff_ph);
    end

    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (i_valid) state_d = ACQ;
                ACQ:     if (close)   state_d = TRACK;
                TRACK:   state_d = TRACK;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            sym_q    <= '0;
            o_bit    <= 1'b0;
            o_valid  <= 1'b0;
            o_phase  <= '0;
            o_locked <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= i_enable ? cur_ph : '0;
            if (!active || close) sym_q <= '0;
            else if (i_valid)     sym_q <= sym_q + NB_WIN'(1);
            if (!i_enable) begin
                o_valid  <= 1'b0;
                o_locked <= 1'b0;
            end else begin
                if (close) begin
                    o_phase  <= sel;
                    o_locked <= 1'b1;
                end
                o_valid <= dec;
                if (dec) o_bit <= i_sample[NB-1];
            end
        end
    end

    // A new window starts with the phase-0 sample that opened it.
    for (genvar g = 0; g < OS; g++) begin : g_acc
        localparam logic IS_PH0 = (g == 0);
        rx_phase_acc #(.NB(NB), .NB_ACC(NB_ACC)) u_acc (
            .clock    (clock),
            .reset    (reset),
            .clear    (!i_enable),
            .load     (start || close),
            .add      (active && (cur_ph == NB_OS'(g))),
            .load_val (IS_PH0 ? mag : '0),
            .mag      (mag),
            .acc      (acc[g])
        );
    end
endmodule

// File: tb/tb_rx_phase_sync.sv
// Scoreboard bench for rx_phase_sync: stimulus queues cycle-tagged expected
// decisions, a monitor matches every o_valid pulse against the queue head.

module tb_rx_phase_sync;
    localparam int NB     = 8;
    localparam int OS     = 4;
    localparam int NB_OS  = 2;
    localparam int NB_WIN = 4;
    localparam int NB_ACC = NB + NB_WIN;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             i_enable = 1'b0;
    logic             i_valid = 1'b0;
    logic [NB-1:0]    i_sample = '0;
    logic             o_bit, o_valid, o_locked;
    logic [NB_OS-1:0] o_phase;

    rx_phase_sync #(.NB(NB), .OS(OS), .NB_OS(NB_OS), .NB_WIN(NB_WIN), .NB_ACC(NB_ACC)) dut (
        .clock    (clock),
        .reset    (reset),
        .i_enable (i_enable),
        .i_valid  (i_valid),
        .i_sample (i_sample),
        .o_bit    (o_bit),
        .o_valid  (o_valid),
        .o_phase  (o_phase),
        .o_locked (o_locked)
    );

    always #5 clock = ~clock;

    typedef struct {int cyc; logic b;} exp_t;
    exp_t q[$];
    int   cyc = 0, n_vec = 0, n_err = 0, n_pulse = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each pulse must land exactly one clock after its sample.
    always @(posedge clock) begin
        #1;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missed_decision: no o_valid at cycle %0d, expected bit %0d", q[0].cyc, q[0].b);
            void'(q.pop_front());
        end
        if (o_valid === 1'b1) begin
            n_pulse++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: o_valid=1 at cycle %0d, none expected", cyc);
            end else begin
                chk("decision_bit", o_bit, q[0].b);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "timeout");
    end

    function automatic logic [NB-1:0] rs(input int amp);
        logic [NB-1:0] v;
        v = NB'(amp);
        return ($urandom_range(0, 1) == 1) ? (~v + NB'(1)) : v;
    endfunction

    task automatic drive(input logic v, input logic [NB-1:0] s, input logic push, input logic en);
        exp_t e;
        @(negedge clock);
        i_valid  = v;
        i_sample = s;
        i_enable = en;
        if (push) begin
            e.cyc = cyc + 1;
            e.b   = s[NB-1];
            q.push_back(e);
        end
    endtask

    // One symbol: strobe on phase 0, +-100 on the dominant phase, +-10 elsewhere.
    task automatic symbol(input int dom, input int exp_ph, input logic fixed, input logic en);
        logic [NB-1:0] s;
        for (int p = 0; p < OS; p++) begin
            s = fixed ? 8'h80 : rs((p == dom) ? 100 : 10);
            drive(p == 0, s, p == exp_ph, en);
        end
    endtask

    task automatic chk_out(input string tag, input int b, input int v, input int ph, input int lk);
        chk({tag, "_o_bit"}, o_bit, b);
        chk({tag, "_o_valid"}, o_valid, v);
        chk({tag, "_o_phase"}, o_phase, ph);
        chk({tag, "_o_locked"}, o_locked, lk);
    endtask

    int p0;

    initial begin
        // Reset held with arbitrary inputs, then released with enable low.
        for (int i = 0; i < 8; i++) drive(1'($urandom_range(0, 1)), NB'($urandom), 1'b0, 1'b1);
        chk_out("reset", 0, 0, 0, 0);
        @(negedge clock);
        reset    = 1'b0;
        i_enable = 1'b0;
        symbol(2, -1, 1'b0, 1'b0);
        symbol(2, -1, 1'b0, 1'b0);
        chk_out("post_reset_disabled", 0, 0, 0, 0);

        // All phases at -128: exact tie, acc = 2048, phase 0 wins, bit = 1.
        for (int k = 0; k < 20; k++) begin
            symbol(0, (k >= 17) ? 0 : -1, 1'b1, 1'b1);
            if (k == 15) chk("tie_locked_before_window", o_locked, 0);
            if (k == 16) begin
                chk("tie_locked", o_locked, 1);
                chk("tie_phase", o_phase, 0);
            end
        end
        chk("tie_last_bit", o_bit, 1);

        // Asynchronous reset mid-operation, checked before any clock edge.
        #2 reset = 1'b1;
        #1 chk_out("async_reset", 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;

        // Enable dropped halfway through the first window.
        for (int k = 0; k < 8; k++) symbol(2, -1, 1'b0, 1'b1);
        symbol(2, -1, 1'b0, 1'b0);
        symbol(2, -1, 1'b0, 1'b0);
        chk("drop_locked", o_locked, 0);
        chk("drop_valid", o_valid, 0);

        // Reacquire, then shift the strobe late by one and move energy around.
        p0 = 0;
        for (int k = 0; k < 52; k++) begin
            if (k == 44) p0 = n_pulse;
            symbol((k <= 20) ? 2 : (k <= 32) ? 1 : 0,
                   (k < 16) ? -1 : (k < 32) ? 2 : (k < 48) ? 1 : 0, 1'b0, 1'b1);
            if (k == 20) drive(1'b0, rs(10), 1'b0, 1'b1);
            if (k == 15) chk("acq_locked_before_window", o_locked, 0);
            if (k == 16) begin
                chk("acq_locked", o_locked, 1);
                chk("acq_phase", o_phase, 2);
            end
            if (k == 31) chk("shift_phase_before_close", o_phase, 2);
            if (k == 32) chk("shift_phase_after_close", o_phase, 1);
            if (k == 47) chk("track_phase_before_close", o_phase, 1);
            if (k == 48) chk("track_phase_after_close", o_phase, 0);
        end
        chk("pulses_across_close", n_pulse - p0, 8);

        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0);
        chk("pending_decisions", q.size(), 0);
        chk("disabled_locked", o_locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rx_phase_sync.md
# rx_phase_sync

Receive-side symbol timing block for the PRBS9/BPSK/RC link. It sits between the RC filter output and the BER checker. It takes one filtered sample per clock (OS samples per symbol) and measures the accumulated magnitude of each of the OS sampling phases over a window of 2^NB_WIN symbols. It then selects the phase with maximum energy and emits one hard BPSK decision per symbol at that phase. This replaces manual, switch-selected sampling offsets with automatic acquisition and continuous tracking.

## Interface
Parameters:
- NB, 8: sample width, signed two's complement.
- OS, 4: oversampling factor, samples per symbol; power of 2, at least 2.
- NB_OS, 2: phase index width, log2(OS).
- NB_WIN, 10: log2 of the window length in symbols.
- NB_ACC, NB+NB_WIN: accumulator width, unsigned.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- i_enable  in  1  RX enable; low forces IDLE.
- i_valid  in  1  symbol strobe, one cycle every OS cycles; marks phase 0.
- i_sample  in  NB  signed filtered sample, new value every clock.
- o_bit  out  1  decided bit: sign of the selected sample (1 = negative).
- o_valid  out  1  one-cycle strobe qualifying o_bit.
- o_phase  out  NB_OS  currently selected sampling phase.
- o_locked  out  1  high once the first window has completed.

## Operation
- Reset values: o_bit=0, o_valid=0, o_phase=0, o_locked=0, FSM=IDLE. All accumulators, the phase counter and the symbol counter are 0.
- Phase counter:
  - Forced to 0 on any cycle with i_valid=1; otherwise increments modulo OS.
  - An early or late i_valid realigns the counter immediately; no error is flagged.
- Magnitude: mag = |i_sample| as an NB-bit unsigned value; -2^(NB-1) maps exactly to 2^(NB-1).
- Accumulation, in ACQ and TRACK: acc[phase] += mag every cycle. There is no saturation: the maximum is 2^NB_WIN * 2^(NB-1), which is less than 2^NB_ACC.
- Symbol counter: increments on each i_valid in ACQ/TRACK.
- Window close: on the i_valid cycle at which the symbol counter has counted 2^NB_WIN complete symbols.
  - sel = argmax(acc[0..OS-1]) is computed combinationally; ties go to the lowest index.
  - o_phase <= sel and o_locked <= 1.
  - acc[0] <= mag of the current sample, all other acc <= 0, symbol counter <= 0.
- FSM:
  - IDLE -> ACQ on the first i_valid with i_enable=1.
  - ACQ -> TRACK at the first window close.
  - TRACK -> TRACK at each subsequent window close; o_phase is re-evaluated each time.
  - Any state -> IDLE when i_enable=0. IDLE clears accumulators and counters and sets o_locked=0 and o_valid=0; o_phase holds its last value.
- Decision, in TRACK only: on the cycle where phase counter == effective phase, o_bit <= i_sample[NB-1] and o_valid <= 1. Otherwise o_valid <= 0 and o_bit holds.
- Effective phase: sel on the window-close cycle, o_phase on all other cycles. This lets phase 0 decide on the close cycle itself.
- No decisions are made in ACQ; o_valid stays 0 until lock.

## Timing
- Decision latency: o_bit/o_valid register one clock after the selected sample is presented.
- o_valid cadence in TRACK: exactly one pulse per symbol, period OS cycles. No pulse is dropped or duplicated at a window close, even when the phase changes. This holds because the close occurs at phase 0, the start of a new symbol.
- First lock:
  - o_locked rises one clock after the i_valid that closes the first window, which is 2^NB_WIN symbols after entering ACQ.
  - The first o_valid follows within OS cycles.
- Reset mid-operation: asynchronous return to the reset values on the reset edge. Reacquisition takes a full window.
- i_enable deassert mid-window: all partial sums are discarded. On re-enable, acquisition waits for the next i_valid.

## Test plan
- **Reset:** reset=1 with arbitrary inputs -> all outputs 0. Release it with i_enable=0 -> outputs remain 0.
- **Acquisition:** NB_WIN=4, OS=4, i_valid every 4 cycles. Drive samples at phase 2 as ±100 (PRBS sign) and other phases as ±10. After 16 symbols plus the close strobe -> o_locked=1 and o_phase=2. o_valid then pulses every 4 cycles, one clock after each phase-2 sample, with o_bit equal to its sign.
- **Tie and extreme magnitude:** all phases driven at -128 -> o_phase=0. Each acc reaches 16*128=2048 with no wrap, and o_bit=1 on every decision.
- **Tracking change:** once locked at phase 2, move the dominant energy to phase 0. At the next window close, o_phase=0 and o_valid fires on the close cycle's sample. o_valid pulses are counted across the close: exactly one per symbol.
- **Enable drop:** deassert i_enable halfway through the first window, then reassert -> o_locked stays 0 for a full 16 symbols from the next i_valid.
- **Misaligned strobe:** shift i_valid by 1 cycle while in TRACK -> the phase counter realigns. o_phase updates at the next window close to the shifted energy peak, and o_valid never pulses twice within one symbol.
